// File: rtl/pong_frame_renderer.sv
// rtl/pong_frame_renderer.sv - Pong game state and registered VGA pixel/sync output for 640x480
// Optional feature macro: PONG_NET_EN draws the dashed centre net.
module pong_frame_renderer #(
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_X     = 600,
    parameter int PADDLE_W     = 4,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_SPEED = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    input  logic        btn_up,
    input  logic        btn_dn,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [11:0] rgb,
    output logic [3:0]  score,
    output logic        miss
);
    localparam logic [10:0] C_BS   = 11'(BALL_SIZE);
    localparam logic [10:0] C_SP   = 11'(BALL_SPEED);
    localparam logic [10:0] C_PX   = 11'(PADDLE_X);
    localparam logic [10:0] C_PW   = 11'(PADDLE_W);
    localparam logic [10:0] C_PH   = 11'(PADDLE_H);
    localparam logic [10:0] C_PS   = 11'(PADDLE_SPEED);
    localparam logic [10:0] C_PMAX = 11'(480 - PADDLE_H);
    localparam logic [9:0]  C_SP10 = 10'(BALL_SPEED);
    localparam logic [9:0]  C_BX0  = 10'd316;
    localparam logic [9:0]  C_BY0  = 10'd236;
    localparam logic [9:0]  C_PY0  = 10'd208;
    localparam logic [7:0]  C_SERVE_LAST = 8'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_MISS} state_t;

    state_t      r_state;
    logic [7:0]  r_serve_cnt;
    logic [9:0]  r_bx, r_by, r_py;
    logic        r_dx_neg, r_dy_neg, r_serve_dy_neg;
    logic [3:0]  r_score;
    logic        r_miss, r_hsync, r_vsync, r_video_on;
    logic [11:0] r_rgb;

    logic [10:0] w_bx, w_by, w_py, w_h, w_v;
    logic        w_frame_tick, w_hit, w_miss, w_lwall, w_top, w_bot;
    logic        w_active, w_in_ball, w_in_paddle, w_in_net;
    logic [9:0]  w_py_next;
    logic [11:0] w_rgb;

    assign w_bx = {1'b0, r_bx};
    assign w_by = {1'b0, r_by};
    assign w_py = {1'b0, r_py};
    assign w_h  = {1'b0, h_count};
    assign w_v  = {1'b0, v_count};

    // The tick sits on the first blanking line, so game state never changes mid-picture.
    assign w_frame_tick = pix_en && (h_count == 10'd0) && (v_count == 10'd480);

    assign w_hit   = !r_dx_neg && (w_bx + C_BS <= C_PX) && (w_bx + C_BS + C_SP >= C_PX)
                     && (w_by + C_BS > w_py) && (w_by < w_py + C_PH);
    assign w_miss  = !r_dx_neg && (w_bx + C_BS + C_SP >= 11'd640);
    assign w_lwall = r_dx_neg && (w_bx <= C_SP);
    assign w_top   = r_dy_neg && (w_by <= C_SP);
    assign w_bot   = !r_dy_neg && (w_by + C_BS + C_SP >= 11'd480);

    always_comb begin
        w_py_next = r_py;
        if (btn_up && !btn_dn)
            w_py_next = (w_py >= C_PS) ? 10'(w_py - C_PS) : 10'd0;
        else if (btn_dn && !btn_up)
            w_py_next = (w_py + C_PS > C_PMAX) ? 10'(C_PMAX) : 10'(w_py + C_PS);
    end

    assign w_active    = (h_count < 10'd640) && (v_count < 10'd480);
    assign w_in_ball   = (w_h >= w_bx) && (w_h < w_bx + C_BS) && (w_v >= w_by) && (w_v < w_by + C_BS);
    assign w_in_paddle = (w_h >= C_PX) && (w_h < C_PX + C_PW) && (w_v >= w_py) && (w_v < w_py + C_PH);
`ifdef PONG_NET_EN
    assign w_in_net    = (h_count >= 10'd318) && (h_count <= 10'd321) && !v_count[4];
`else
    assign w_in_net    = 1'b0;
`endif

    always_comb begin
        w_rgb = 12'h000;
        if (w_active) begin
            if (w_in_ball)        w_rgb = 12'hFFF;
            else if (w_in_paddle) w_rgb = 12'h0F0;
            else if (w_in_net)    w_rgb = 12'h888;
        end
    end

    always_ff @(posedge clk) begin
        r_miss <= 1'b0;
        if (rst) begin
            r_state        <= S_SERVE;
            r_serve_cnt    <= 8'd0;
            r_bx           <= C_BX0;
            r_by           <= C_BY0;
            r_py           <= C_PY0;
            r_dx_neg       <= 1'b0;
            r_dy_neg       <= 1'b0;
            r_serve_dy_neg <= 1'b0;
            r_score        <= 4'd0;
            r_hsync        <= 1'b1;
            r_vsync        <= 1'b1;
            r_video_on     <= 1'b0;
            r_rgb          <= 12'h000;
        end else if (pix_en) begin
            r_hsync    <= !((h_count >= 10'd656) && (h_count <= 10'd751));
            r_vsync    <= !((v_count >= 10'd490) && (v_count <= 10'd491));
            r_video_on <= w_active;
            r_rgb      <= w_rgb;
            if (w_frame_tick) begin
                r_py <= w_py_next;
                case (r_state)
                    S_SERVE: begin
                        if (r_serve_cnt == C_SERVE_LAST) begin
                            r_state     <= S_PLAY;
                            r_serve_cnt <= 8'd0;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + 8'd1;
                        end
                    end
                    S_PLAY: begin
                        if (w_hit) begin
                            r_bx     <= 10'(C_PX - C_BS);
                            r_dx_neg <= 1'b1;
                            r_score  <= r_score + 4'd1;
                        end else if (w_miss) begin
                            r_state <= S_MISS;
                            r_miss  <= 1'b1;
                        end else if (w_lwall) begin
                            r_bx     <= 10'd0;
                            r_dx_neg <= 1'b0;
                        end else if (r_dx_neg) begin
                            r_bx <= r_bx - C_SP10;
                        end else begin
                            r_bx <= r_bx + C_SP10;
                        end
                        // Y is independent of X so corner bounces apply both axes at once.
                        if (w_top) begin
                            r_by     <= 10'd0;
                            r_dy_neg <= 1'b0;
                        end else if (w_bot) begin
                            r_by     <= 10'(11'd480 - C_BS);
                            r_dy_neg <= 1'b1;
                        end else if (r_dy_neg) begin
                            r_by <= r_by - C_SP10;
                        end else begin
                            r_by <= r_by + C_SP10;
                        end
                    end
                    S_MISS: begin
                        r_score        <= 4'd0;
                        r_bx           <= C_BX0;
                        r_by           <= C_BY0;
                        r_dx_neg       <= 1'b0;
                        r_serve_dy_neg <= !r_serve_dy_neg;
                        r_dy_neg       <= !r_serve_dy_neg;
                        r_state        <= S_SERVE;
                    end
                    default: r_state <= S_SERVE;
                endcase
            end
        end
    end

    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign video_on = r_video_on;
    assign rgb      = r_rgb;
    assign score    = r_score;
    assign miss     = r_miss;
endmodule

// File: tb/tb_pong_frame_renderer.sv
// tb/tb_pong_frame_renderer.sv - scoreboard bench for pong_frame_renderer against a behavioural game model
module tb_pong_frame_renderer;
    logic        clk = 1'b0;
    logic        rst, pix_en, btn_up, btn_dn;
    logic [9:0]  h_count, v_count;
    logic        hsync, vsync, video_on, miss;
    logic [11:0] rgb;
    logic [3:0]  score;

    always #5 clk = ~clk;

    pong_frame_renderer dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .h_count(h_count), .v_count(v_count),
        .btn_up(btn_up), .btn_dn(btn_dn), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .rgb(rgb), .score(score), .miss(miss)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        von;
        logic [11:0] rgb;
        logic [3:0]  score;
        logic        miss;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Game model: positions in pixels, directions as +1/-1, state 0=serve 1=play 2=miss.
    int m_bx, m_by, m_dx, m_dy, m_py, m_score, m_state, m_cnt, m_serve_dy;

    task automatic model_reset();
        m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1; m_py = 208;
        m_score = 0; m_state = 0; m_cnt = 0; m_serve_dy = 1;
    endtask

    function automatic logic [11:0] model_pixel(input int h, input int v);
        if (h >= 640 || v >= 480) return 12'h000;
        if (h >= m_bx && h < m_bx + 8 && v >= m_by && v < m_by + 8) return 12'hFFF;
        if (h >= 600 && h < 604 && v >= m_py && v < m_py + 64) return 12'h0F0;
`ifdef PONG_NET_EN
        if (h >= 318 && h <= 321 && ((v / 16) % 2) == 0) return 12'h888;
`endif
        return 12'h000;
    endfunction

    task automatic model_tick(input bit up, input bit dn, output bit missf);
        int old_py = m_py;
        missf = 1'b0;
        if (up && !dn)      m_py = (m_py - 4 < 0) ? 0 : m_py - 4;
        else if (dn && !up) m_py = (m_py + 4 > 416) ? 416 : m_py + 4;
        case (m_state)
            0: begin
                if (m_cnt == 59) begin m_state = 1; m_cnt = 0; end
                else m_cnt++;
            end
            1: begin
                if (m_dx > 0 && m_bx + 8 <= 600 && m_bx + 10 >= 600 && m_by + 8 > old_py && m_by < old_py + 64) begin
                    m_bx = 592; m_dx = -1; m_score = (m_score + 1) % 16;
                end else if (m_dx > 0 && m_bx + 10 >= 640) begin
                    m_state = 2; missf = 1'b1;
                end else if (m_dx < 0 && m_bx <= 2) begin
                    m_bx = 0; m_dx = 1;
                end else begin
                    m_bx = m_bx + 2 * m_dx;
                end
                if (m_dy < 0 && m_by <= 2) begin m_by = 0; m_dy = 1; end
                else if (m_dy > 0 && m_by + 10 >= 480) begin m_by = 472; m_dy = -1; end
                else m_by = m_by + 2 * m_dy;
            end
            default: begin
                m_score = 0; m_bx = 316; m_by = 236; m_dx = 1;
                m_serve_dy = -m_serve_dy; m_dy = m_serve_dy; m_state = 0;
            end
        endcase
    endtask

    task automatic drive(input bit r, input bit pe, input int h_in, input int v_in, input bit up, input bit dn);
        exp_t e;
        bit   mf;
        int   h, v;
        h = h_in & 1023;
        v = v_in & 1023;
        @(negedge clk);
        rst = r; pix_en = pe; h_count = 10'(h); v_count = 10'(v); btn_up = up; btn_dn = dn;
        e = last_exp;
        if (r) begin
            model_reset();
            e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0; e.rgb = 12'h000; e.score = 4'd0; e.miss = 1'b0;
        end else if (pe) begin
            e.hs  = !(h >= 656 && h <= 751);
            e.vs  = !(v >= 490 && v <= 491);
            e.von = (h < 640 && v < 480);
            e.rgb = model_pixel(h, v);
            mf = 1'b0;
            if (h == 0 && v == 480) model_tick(up, dn, mf);
            e.score = 4'(m_score);
            e.miss  = mf;
        end else begin
            e.miss = 1'b0;
        end
        last_exp = e;
        exp_q.push_back(e);
    endtask

    task automatic sample(input bit pe, input bit up, input bit dn);
        int h, v;
        case ($urandom_range(0, 11))
            0:  begin h = m_bx;     v = m_by; end
            1:  begin h = m_bx + 7; v = m_by + 7; end
            2:  begin h = m_bx + 8; v = m_by + $urandom_range(0, 7); end
            3:  begin h = m_bx - 1; v = m_by + $urandom_range(0, 8); end
            4:  begin h = 600 + $urandom_range(0, 3); v = m_py; end
            5:  begin h = 604; v = m_py + $urandom_range(0, 63); end
            6:  begin h = 600; v = m_py + 63 + $urandom_range(0, 1); end
            7:  begin h = $urandom_range(599, 603); v = m_py - 1; end
            8:  begin h = $urandom_range(654, 754); v = $urandom_range(0, 524); end
            9:  begin h = $urandom_range(0, 799); v = $urandom_range(486, 495); end
            10: begin h = $urandom_range(636, 643); v = $urandom_range(476, 483); end
            default: begin h = $urandom_range(0, 799); v = $urandom_range(0, 524); end
        endcase
        drive(1'b0, pe, h, v, up, dn);
    endtask

    task automatic frame(input int nsamp, input bit up, input bit dn, input bit rand_pe);
        for (int i = 0; i < nsamp; i++)
            sample(rand_pe ? ($urandom_range(0, 3) != 0) : 1'b1, up, dn);
        drive(1'b0, rand_pe ? ($urandom_range(0, 5) != 0) : 1'b1, 0, 480, up, dn);
    endtask

    // Monitor: registered outputs are valid one clock after each driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({hsync, vsync, video_on, rgb, score, miss} !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got hs=%b vs=%b von=%b rgb=%h score=%0d miss=%b, want hs=%b vs=%b von=%b rgb=%h score=%0d miss=%b",
                             $time, hsync, vsync, video_on, rgb, score, miss,
                             e.hs, e.vs, e.von, e.rgb, e.score, e.miss);
                end
            end
        end
    end

    initial begin
        bit up, dn;
        rst = 1'b1; pix_en = 1'b0; h_count = '0; v_count = '0; btn_up = 1'b0; btn_dn = 1'b0;
        last_exp = '0;
        model_reset();

        drive(1'b1, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) sample(1'b1, 0, 0);

        // Idle serve period and first launch.
        for (int f = 0; f < 70; f++) frame(2, 0, 0, 0);

        // Reset held mid-frame, then rendering resumes.
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom_range(0, 1), 300, 200, 0, 0);
        for (int f = 0; f < 5; f++) frame(2, 0, 0, 0);

        // Paddle follows the ball to rack up hits and wrap the score.
        for (int f = 0; f < 10500; f++) begin
            up = (m_py + 32) > (m_by + 8);
            dn = (m_py + 32) < (m_by);
            frame(1, up, dn, 0);
        end

        // Paddle pinned to the top: repeated misses.
        for (int f = 0; f < 1500; f++) frame(1, 1, 0, 0);

        // Paddle driven into the bottom clamp.
        for (int f = 0; f < 200; f++) frame(1, 0, 1, 0);

        // Random buttons with gaps in pix_en.
        for (int f = 0; f < 800; f++) frame(2, $urandom_range(0, 1), $urandom_range(0, 1), 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
